hazard_ctrl: RTL and testbench

Pipeline hazard controller that sequences the execute stage. It tracks the destination registers of the instructions in EXE, MEM and WB, and generates the registered `rs1_sel`/`rs2_sel` forwarding selects for the instruction entering EXE. It also generates the stall, bubble and flush controls for load-use hazards, data-memory waits and taken branches or jumps. It sits beside the DE/EXE/MEM/WB pipeline registers and drives their load enables.

---
 rtl/hazard_ctrl_pkg.sv | 49 ++++
 rtl/hazard_ctrl_fwd_match.sv | 30 +++
 rtl/hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the execute-stage hazard controller: forward-select encodings,
// controller states and the per-stage scoreboard entry.
package rs1mux;
    typedef enum logic [1:0] {
        RS1_RF  = 2'b00,
        RS1_EXE = 2'b01,
        RS1_MEM = 2'b10,
        RS1_WB  = 2'b11
    } rs1_sel_t;
endpackage

package rs2mux;
    typedef enum logic [1:0] {
        RS2_RF  = 2'b00,
        RS2_EXE = 2'b01,
        RS2_MEM = 2'b10,
        RS2_WB  = 2'b11
    } rs2_sel_t;
endpackage

package cpuIO;
    typedef rs1mux::rs1_sel_t rs1_sel_t;
    typedef rs2mux::rs2_sel_t rs2_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       ld_reg;
        logic       is_load;
    } sb_entry_t;

    // Index 0 is EXE, 1 is MEM, 2 is WB.
    localparam int SB_DEPTH = 3;

    // Stages whose load data is not yet available for forwarding.
    localparam logic [SB_DEPTH-1:0] LOAD_STALL_MASK = 3'b001;

    localparam sb_entry_t SB_EMPTY = '0;

    function automatic logic [1:0] stage_sel(input int idx);
        return 2'(idx + 1);
    endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// Combinational source-operand matcher: picks the youngest in-flight producer of
// one source register and flags a load that cannot yet be forwarded.
module fwd_match
    import cpuIO::*;
(
    input  sb_entry_t [SB_DEPTH-1:0] i_sb,
    input  logic [4:0]               i_rs,
    input  logic                     i_uses,
    output logic [1:0]               o_sel,
    output logic                     o_load_hit
);
    logic [SB_DEPTH-1:0] w_hit;
    logic [SB_DEPTH-1:0] w_is_load;

    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_stage
        assign w_hit[gi] = i_uses && i_sb[gi].valid && i_sb[gi].ld_reg &&
                           (i_sb[gi].rd != 5'd0) && (i_sb[gi].rd == i_rs);
        assign w_is_load[gi] = i_sb[gi].is_load;
    end

    // Walk from WB down to EXE so the youngest producer wins.
    always_comb begin
        o_sel = 2'b00;
        for (int i = SB_DEPTH - 1; i >= 0; i--) begin
            if (w_hit[i]) o_sel = stage_sel(i);
        end
    end

    assign o_load_hit = |(w_hit & w_is_load & LOAD_STALL_MASK);
endmodule

// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: scoreboard of EXE/MEM/WB destinations,
// registered forward selects, and stall/bubble/flush sequencing.
module hazard_ctrl
    import cpuIO::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       de_valid,
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       de_uses_rs1,
    input  logic       de_uses_rs2,
    input  logic [4:0] de_rd,
    input  logic       de_ld_reg,
    input  logic       de_is_load,
    input  logic       exe_redirect,
    input  logic       dmem_req,
    input  logic       dmem_resp,
    output logic       pipe_adv,
    output logic       de_hold,
    output logic       exe_bubble,
    output logic       flush_de,
    output logic [1:0] rs1_sel,
    output logic [1:0] rs2_sel,
    output logic       busy
);
    hz_state_t                r_state;
    hz_state_t                w_state_next;
    logic [1:0]               r_flush_cnt;
    logic [1:0]               w_flush_cnt_next;
    sb_entry_t [SB_DEPTH-1:0] r_sb;
    rs1_sel_t                 r_rs1_sel;
    rs2_sel_t                 r_rs2_sel;

    logic [4:0] w_rs   [2];
    logic       w_uses [2];
    logic [1:0] w_sel  [2];
    logic       w_lh   [2];
    logic       w_mem_wait;
    logic       w_load_use;

    assign w_rs[0]   = de_rs1;
    assign w_rs[1]   = de_rs2;
    assign w_uses[0] = de_valid && de_uses_rs1;
    assign w_uses[1] = de_valid && de_uses_rs2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        fwd_match u_match (
            .i_sb       (r_sb),
            .i_rs       (w_rs[gi]),
            .i_uses     (w_uses[gi]),
            .o_sel      (w_sel[gi]),
            .o_load_hit (w_lh[gi])
        );
    end

    // Once waiting, only the response releases; otherwise a new unanswered request freezes.
    assign w_mem_wait = (r_state == MEM_WAIT) ? !dmem_resp : (dmem_req && !dmem_resp);
    assign w_load_use = w_lh[0] || w_lh[1];

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        pipe_adv         = 1'b1;
        de_hold          = 1'b0;
        exe_bubble       = 1'b0;
        flush_de         = 1'b0;
        if (w_mem_wait) begin
            pipe_adv = 1'b0;
            de_hold  = 1'b1;
            if (r_state == RUN) w_state_next = MEM_WAIT;
        end else if (r_state == FLUSH) begin
            exe_bubble = 1'b1;
            if (r_flush_cnt <= 2'd1) begin
                w_state_next     = RUN;
                w_flush_cnt_next = 2'd0;
            end else begin
                w_flush_cnt_next = r_flush_cnt - 2'd1;
            end
        end else if (exe_redirect) begin
            flush_de         = 1'b1;
            w_state_next     = FLUSH;
            w_flush_cnt_next = FLUSH_CYCLES[1:0];
        end else begin
            w_state_next = RUN;
            if (w_load_use) begin
                de_hold    = 1'b1;
                exe_bubble = 1'b1;
            end
        end
    end

    assign busy    = (r_state != RUN);
    assign rs1_sel = r_rs1_sel;
    assign rs2_sel = r_rs2_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_flush_cnt <= 2'd0;
            r_sb        <= {SB_DEPTH{SB_EMPTY}};
            r_rs1_sel   <= rs1mux::RS1_RF;
            r_rs2_sel   <= rs2mux::RS2_RF;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            if (pipe_adv) begin
                for (int i = SB_DEPTH - 1; i > 0; i--) begin
                    r_sb[i] <= r_sb[i-1];
                end
                if (exe_bubble || flush_de || !de_valid) begin
                    r_sb[0]   <= SB_EMPTY;
                    r_rs1_sel <= rs1mux::RS1_RF;
                    r_rs2_sel <= rs2mux::RS2_RF;
                end else begin
                    r_sb[0]   <= '{valid: 1'b1, rd: de_rd, ld_reg: de_ld_reg, is_load: de_is_load};
                    r_rs1_sel <= rs1_sel_t'(w_sel[0]);
                    r_rs2_sel <= rs2_sel_t'(w_sel[1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-by-cycle vector table through forwarding,
// load-use, redirect and memory-wait cases, plus asynchronous-reset sequences.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       de_valid, de_uses_rs1, de_uses_rs2, de_ld_reg, de_is_load;
    logic [4:0] de_rs1, de_rs2, de_rd;
    logic       exe_redirect, dmem_req, dmem_resp;
    logic       pipe_adv, de_hold, exe_bubble, flush_de, busy;
    logic [1:0] rs1_sel, rs2_sel;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2),
        .de_rd(de_rd), .de_ld_reg(de_ld_reg), .de_is_load(de_is_load),
        .exe_redirect(exe_redirect), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .pipe_adv(pipe_adv), .de_hold(de_hold), .exe_bubble(exe_bubble),
        .flush_de(flush_de), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       dv;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       ld, isld;
        logic       redir, req, resp;
        logic       e_adv, e_hold, e_bub, e_flush, e_busy;
        logic [1:0] e_s1, e_s2;
    } vec_t;

    vec_t tbl[$];

    // RUN-state vector: a load-use stall is the only control change.
    function automatic vec_t rv(input string n, input logic dv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic u1, input logic u2,
                                input logic [4:0] rd, input logic ld, input logic isld,
                                input logic hold, input logic [1:0] s1, input logic [1:0] s2);
        vec_t v;
        v.name = n; v.dv = dv; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.rd = rd; v.ld = ld; v.isld = isld;
        v.redir = 1'b0; v.req = 1'b0; v.resp = 1'b0;
        v.e_adv = 1'b1; v.e_hold = hold; v.e_bub = hold; v.e_flush = 1'b0; v.e_busy = 1'b0;
        v.e_s1 = s1; v.e_s2 = s2;
        return v;
    endfunction

    function automatic vec_t xv(input string n, input logic redir, input logic req,
                                input logic resp, input logic dv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic isld,
                                input logic adv, input logic hold, input logic bub,
                                input logic fl, input logic bsy,
                                input logic [1:0] s1, input logic [1:0] s2);
        vec_t v;
        v = rv(n, dv, rs1, rs2, 1'b1, 1'b1, rd, 1'b1, isld, hold, s1, s2);
        v.redir = redir; v.req = req; v.resp = resp;
        v.e_adv = adv; v.e_bub = bub; v.e_flush = fl; v.e_busy = bsy;
        return v;
    endfunction

    task automatic chk(input string n, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", n, act, exp);
        end
    endtask

    task automatic set_idle();
        de_valid = 0; de_rs1 = 0; de_rs2 = 0; de_uses_rs1 = 0; de_uses_rs2 = 0;
        de_rd = 0; de_ld_reg = 0; de_is_load = 0;
        exe_redirect = 0; dmem_req = 0; dmem_resp = 0;
    endtask

    task automatic chk_reset_outputs(input string n);
        chk({n, ".adv"},   {1'b0, pipe_adv},   2'd1);
        chk({n, ".hold"},  {1'b0, de_hold},    2'd0);
        chk({n, ".bub"},   {1'b0, exe_bubble}, 2'd0);
        chk({n, ".flush"}, {1'b0, flush_de},   2'd0);
        chk({n, ".busy"},  {1'b0, busy},       2'd0);
        chk({n, ".s1"},    rs1_sel,            2'd0);
        chk({n, ".s2"},    rs2_sel,            2'd0);
    endtask

    // Entered just after a falling edge; returns at the next falling edge.
    task automatic run_vec(input vec_t v);
        de_valid = v.dv; de_rs1 = v.rs1; de_rs2 = v.rs2;
        de_uses_rs1 = v.u1; de_uses_rs2 = v.u2; de_rd = v.rd;
        de_ld_reg = v.ld; de_is_load = v.isld;
        exe_redirect = v.redir; dmem_req = v.req; dmem_resp = v.resp;
        #1;
        chk({v.name, ".adv"},   {1'b0, pipe_adv},   {1'b0, v.e_adv});
        chk({v.name, ".hold"},  {1'b0, de_hold},    {1'b0, v.e_hold});
        chk({v.name, ".bub"},   {1'b0, exe_bubble}, {1'b0, v.e_bub});
        chk({v.name, ".flush"}, {1'b0, flush_de},   {1'b0, v.e_flush});
        chk({v.name, ".busy"},  {1'b0, busy},       {1'b0, v.e_busy});
        @(posedge clk);
        #1;
        chk({v.name, ".s1"}, rs1_sel, v.e_s1);
        chk({v.name, ".s2"}, rs2_sel, v.e_s2);
        $display("vec %-18s adv=%b hold=%b bub=%b flush=%b busy=%b sel=%0d/%0d",
                 v.name, pipe_adv, de_hold, exe_bubble, flush_de, busy, rs1_sel, rs2_sel);
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Forwarding distance 1/2/3, priority, uses/ld_reg/x0 filtering, load-use.
        tbl.push_back(rv("prod_x1",      1,  3,  4, 1, 1,  1, 1, 0, 0, 0, 0));
        tbl.push_back(rv("fwd_exe",      1,  1,  1, 1, 1,  2, 1, 0, 0, 1, 1));
        tbl.push_back(rv("prod_x7",      1,  3,  4, 1, 1,  7, 1, 0, 0, 0, 0));
        tbl.push_back(rv("nop_inv",      0,  7,  7, 1, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("fwd_mem",      1,  7,  7, 1, 1,  8, 1, 0, 0, 2, 2));
        tbl.push_back(rv("prod_x9",      1,  3,  4, 1, 1,  9, 1, 0, 0, 0, 0));
        tbl.push_back(rv("nop1",         0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("nop2",         0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("fwd_wb",       1,  9,  9, 1, 1, 10, 1, 0, 0, 3, 3));
        tbl.push_back(rv("prod_x10b",    1,  3,  4, 1, 1, 10, 1, 0, 0, 0, 0));
        tbl.push_back(rv("prio_uses_off",1, 10, 10, 1, 0, 11, 1, 0, 0, 1, 0));
        tbl.push_back(rv("no_ldreg",     1,  3,  4, 1, 1, 12, 0, 0, 0, 0, 0));
        tbl.push_back(rv("ldreg0_mem",   1, 12, 11, 1, 1, 13, 1, 0, 0, 0, 2));
        tbl.push_back(rv("prod_x0",      1,  3,  4, 1, 1,  0, 1, 0, 0, 0, 0));
        tbl.push_back(rv("read_x0",      1,  0,  0, 1, 1, 14, 1, 0, 0, 0, 0));
        tbl.push_back(rv("lw_x0",        1,  3,  4, 1, 1,  0, 1, 1, 0, 0, 0));
        tbl.push_back(rv("x0_no_stall",  1,  0,  0, 1, 1, 16, 1, 0, 0, 0, 0));
        tbl.push_back(rv("lw_x5",        1,  3,  4, 1, 0,  5, 1, 1, 0, 0, 0));
        tbl.push_back(rv("ld_use",       1,  5,  0, 1, 1,  6, 1, 0, 1, 0, 0));
        tbl.push_back(rv("ld_use_mem",   1,  5,  0, 1, 1,  6, 1, 0, 0, 2, 0));
        tbl.push_back(rv("lw_x7",        1,  3,  4, 1, 1,  7, 1, 1, 0, 0, 0));
        tbl.push_back(rv("inv_after_lw", 0,  4,  7, 1, 1,  0, 0, 0, 0, 0, 0));
        tbl.push_back(rv("lw_in_mem",    1,  3,  7, 1, 1, 15, 1, 0, 0, 0, 2));
        tbl.push_back(rv("lw_x21",       1,  3,  4, 1, 1, 21, 1, 1, 0, 0, 0));
        // Redirect squashing a would-be load-use consumer, then two flush bubbles.
        tbl.push_back(xv("redir_cancel_lu", 1, 0, 0, 1, 21,  4, 20, 0, 1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(xv("flush1",          0, 0, 0, 1, 20, 20, 22, 0, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(xv("flush2",          0, 0, 0, 1, 20, 20, 22, 0, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(xv("flush_done",      0, 0, 0, 1, 20, 20, 22, 0, 1, 0, 0, 0, 0, 0, 0));
        // Four-cycle memory wait with a redirect parked in EXE; selects must hold at 01.
        tbl.push_back(xv("prod_x23",        0, 0, 0, 1, 22, 22, 23, 0, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(xv("mw_enter",        1, 1, 0, 1,  3,  4, 24, 0, 0, 1, 0, 0, 0, 1, 1));
        tbl.push_back(xv("mw_1",            1, 1, 0, 1,  3,  4, 24, 0, 0, 1, 0, 0, 1, 1, 1));
        tbl.push_back(xv("mw_2",            1, 1, 0, 1,  3,  4, 24, 0, 0, 1, 0, 0, 1, 1, 1));
        tbl.push_back(xv("mw_release",      1, 1, 1, 1,  3,  4, 24, 0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(xv("mw_flush1",       0, 0, 0, 1,  3,  4, 24, 0, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(xv("mw_flush2",       0, 0, 0, 1,  3,  4, 24, 0, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(xv("mw_run",          0, 0, 0, 1,  3,  4, 24, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(xv("req_resp_same",   0, 1, 1, 1, 24,  3, 25, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(xv("no_wait",         0, 0, 0, 1,  3,  4, 26, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(xv("pre_rst_prod",    0, 0, 0, 1,  3,  4, 27, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(xv("pre_rst_fwd",     0, 0, 0, 1, 27,  3, 28, 0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(xv("mw_before_rst",   0, 1, 0, 1,  3,  4, 29, 0, 0, 1, 0, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // Reset asserted while frozen in MEM_WAIT with a non-zero select held.
        set_idle();
        dmem_req = 1'b1;
        #1;
        chk("mw_hold.busy", {1'b0, busy}, 2'd1);
        chk("mw_hold.s1", rs1_sel, 2'd1);
        dmem_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk_reset_outputs("rst_in_mw");
        #1 rst = 1'b1;
        @(negedge clk);
        run_vec(xv("post_rst_run", 0, 0, 0, 1, 28, 3, 30, 0, 1, 0, 0, 0, 0, 0, 0));

        // Reset asserted mid-flush; the bubble counter must not resume.
        run_vec(xv("redir2",  1, 0, 0, 1, 3, 4, 31, 0, 1, 0, 0, 1, 0, 0, 0));
        run_vec(xv("flush_a", 0, 0, 0, 1, 3, 4, 31, 0, 1, 0, 1, 0, 1, 0, 0));
        set_idle();
        #1;
        chk("flush_b.bub", {1'b0, exe_bubble}, 2'd1);
        #1 rst = 1'b0;
        #1;
        chk_reset_outputs("rst_in_flush");
        #1 rst = 1'b1;
        @(negedge clk);
        run_vec(xv("post_rst_flush", 0, 0, 0, 1, 3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
